// File: rtl/ds_link_rx_if.sv
// Character handshake between the DS-link receiver and the node's RX FIFO.
// The receiver (master) presents a raw character with rx_valid; the FIFO
// (slave) accepts it with rx_ready.
interface ds_link_rx_if #(
    parameter int G_CHAR_BITS = 10
);
    logic [G_CHAR_BITS-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/ds_link_rx.sv
// IEEE1355 DS-link receive front end.
// Oversamples the asynchronous Data/Strobe pair, recovers one bit per
// transition, assembles raw characters (bit 0 first) and offers them through
// a one-entry holding register. Flags DS encoding errors (both lines toggled
// in one sample), link disconnect (no bit event for G_DISC_CYCLES clocks) and
// characters dropped because the holding register was still occupied.
module ds_link_rx #(
    parameter int G_CHAR_BITS   = 10,
    parameter int G_DISC_CYCLES = 85,
    parameter int G_SYNC_STAGES = 2
) (
    input  logic         CLK100MHZ,
    input  logic         rst_n,
    input  logic         D_in,
    input  logic         S_in,
    ds_link_rx_if.master rx_if,
    output logic         rx_overrun,
    output logic         ds_error,
    output logic         disconnect,
    output logic         link_active
);

    localparam int CNT_W = (G_CHAR_BITS > 1) ? $clog2(G_CHAR_BITS) : 1;
    localparam int TO_W  = $clog2(G_DISC_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(G_CHAR_BITS - 1);
    localparam logic [TO_W-1:0]  DISC_MAX = TO_W'(G_DISC_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Input synchronisers and previous-sample registers
    logic [G_SYNC_STAGES-1:0] d_sync_q, d_sync_d;
    logic [G_SYNC_STAGES-1:0] s_sync_q, s_sync_d;
    logic                     d_p_q, d_p_d;
    logic                     s_p_q, s_p_d;

    // Character assembly and link supervision
    state_t                   state_q, state_d;
    logic [G_CHAR_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
    logic                     ds_error_q, ds_error_d;
    logic                     disconnect_q, disconnect_d;

    // Holding register towards the FIFO
    logic [G_CHAR_BITS-1:0]   rx_data_q, rx_data_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     rx_overrun_q, rx_overrun_d;

    logic                     d_s, s_s;
    logic                     d_tog, s_tog;
    logic                     bit_evt, both_evt;
    logic                     char_done;
    logic [G_CHAR_BITS-1:0]   char_word;

    assign d_s      = d_sync_q[G_SYNC_STAGES-1];
    assign s_s      = s_sync_q[G_SYNC_STAGES-1];
    assign d_tog    = d_s ^ d_p_q;
    assign s_tog    = s_s ^ s_p_q;
    // Exactly one line toggling carries a bit; both toggling is an encoding error.
    assign bit_evt  = d_tog ^ s_tog;
    assign both_evt = d_tog & s_tog;
    // New bits enter at the top, so after G_CHAR_BITS shifts the first bit sits at bit 0.
    assign char_word = {d_s, shift_q[G_CHAR_BITS-1:1]};

    // Shift raw inputs through the synchroniser chains and keep the previous synchronised sample.
    always_comb begin
        d_sync_d = {d_sync_q[G_SYNC_STAGES-2:0], D_in};
        s_sync_d = {s_sync_q[G_SYNC_STAGES-2:0], S_in};
        d_p_d    = d_s;
        s_p_d    = s_s;
    end

    // Bit assembly, encoding-error handling and IDLE/RUN supervision with the idle timeout.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        to_cnt_d     = to_cnt_q;
        ds_error_d   = 1'b0;
        disconnect_d = 1'b0;
        char_done    = 1'b0;

        if (both_evt) begin
            ds_error_d = 1'b1;
            shift_d    = '0;
            bit_cnt_d  = '0;
        end else if (bit_evt) begin
            if (bit_cnt_q == LAST_BIT) begin
                char_done = 1'b1;
                shift_d   = '0;
                bit_cnt_d = '0;
            end else begin
                shift_d   = char_word;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (bit_evt || both_evt) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bit_evt || both_evt) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q != DISC_MAX) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
                // Silence for the full window: drop the link and any partial character.
                if (to_cnt_d == DISC_MAX) begin
                    state_d      = ST_IDLE;
                    disconnect_d = 1'b1;
                    to_cnt_d     = '0;
                    shift_d      = '0;
                    bit_cnt_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One-entry holding register: load on completion if free (or being emptied now), else flag overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = 1'b0;

        if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (char_done) begin
            if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_d  = char_word;
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end
    end

    // Front-end registers: synchronisers and previous-sample flops.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            d_sync_q <= '0;
            s_sync_q <= '0;
            d_p_q    <= 1'b0;
            s_p_q    <= 1'b0;
        end else begin
            d_sync_q <= d_sync_d;
            s_sync_q <= s_sync_d;
            d_p_q    <= d_p_d;
            s_p_q    <= s_p_d;
        end
    end

    // State register plus assembly, timeout and output registers.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            ds_error_q   <= 1'b0;
            disconnect_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            ds_error_q   <= ds_error_d;
            disconnect_q <= disconnect_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rx_if.rx_data  = rx_data_q;
    assign rx_if.rx_valid = rx_valid_q;
    assign rx_overrun     = rx_overrun_q;
    assign ds_error       = ds_error_q;
    assign disconnect     = disconnect_q;
    assign link_active    = (state_q == ST_RUN);

endmodule

// File: tb/tb_ds_link_rx.sv
// Bench for ds_link_rx: a DS-encoding transmitter drives D/S, a negedge
// monitor collects accepted characters and counts status pulses, and each
// scenario task compares against the characters it chose to send.
module tb_ds_link_rx;

    localparam int N    = 10;
    localparam int DISC = 85;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic d_in;
    logic s_in;
    logic rx_overrun;
    logic ds_error;
    logic disconnect;
    logic link_active;

    ds_link_rx_if #(.G_CHAR_BITS(N)) rx_if ();

    ds_link_rx #(
        .G_CHAR_BITS  (N),
        .G_DISC_CYCLES(DISC),
        .G_SYNC_STAGES(SYNC)
    ) dut (
        .CLK100MHZ  (clk),
        .rst_n      (rst_n),
        .D_in       (d_in),
        .S_in       (s_in),
        .rx_if      (rx_if),
        .rx_overrun (rx_overrun),
        .ds_error   (ds_error),
        .disconnect (disconnect),
        .link_active(link_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: accepted characters and pulse counts, sampled mid-cycle.
    logic [N-1:0] rxq[$];
    int ovr_cnt  = 0;
    int dse_cnt  = 0;
    int disc_cnt = 0;
    int disc_cyc = 0;
    always @(negedge clk) begin
        if (rx_if.rx_valid && rx_if.rx_ready) rxq.push_back(rx_if.rx_data);
        if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
        if (ds_error)   dse_cnt <= dse_cnt + 1;
        if (disconnect) begin
            disc_cnt <= disc_cnt + 1;
            disc_cyc <= cyc;
        end
    end

    // Transmitter line state and bookkeeping.
    logic tx_d = 1'b0;
    logic tx_s = 1'b0;
    int   last_drive_cyc = 0;
    int   b_ovr, b_dse, b_disc;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // DS encoding: D carries the bit, S toggles whenever D does not.
    task automatic send_bit(input logic b, input int per);
        if (b != tx_d) tx_d = b;
        else           tx_s = ~tx_s;
        d_in = tx_d;
        s_in = tx_s;
        last_drive_cyc = cyc;
        tick(per);
    endtask

    task automatic send_char(input logic [N-1:0] c, input int per);
        for (int k = 0; k < N; k++) send_bit(c[k], per);
    endtask

    task automatic baseline();
        rxq.delete();
        b_ovr  = ovr_cnt;
        b_dse  = dse_cnt;
        b_disc = disc_cnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d_in = 1'b0; s_in = 1'b0; tx_d = 1'b0; tx_s = 1'b0;
        rx_if.rx_ready = 1'b1;
        tick(3);
        n_checks++; if (rx_if.rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", rx_if.rx_valid); end
        n_checks++; if (rx_if.rx_data !== '0) begin n_errors++; $display("FAIL reset_data: got %h expected 000", rx_if.rx_data); end
        n_checks++; if (rx_overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
        n_checks++; if (ds_error !== 1'b0) begin n_errors++; $display("FAIL reset_ds_error: got %b expected 0", ds_error); end
        n_checks++; if (disconnect !== 1'b0) begin n_errors++; $display("FAIL reset_disconnect: got %b expected 0", disconnect); end
        n_checks++; if (link_active !== 1'b0) begin n_errors++; $display("FAIL reset_link_active: got %b expected 0", link_active); end
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_single();
        baseline();
        send_char(10'h3C3, 4);
        tick(4);
        n_checks++; if (rxq.size() !== 1) begin n_errors++; $display("FAIL single_count: got %0d expected 1", rxq.size()); end
        if (rxq.size() > 0) begin
            n_checks++; if (rxq[0] !== 10'h3C3) begin n_errors++; $display("FAIL single_data: got %h expected 3c3", rxq[0]); end
        end
        n_checks++; if (link_active !== 1'b1) begin n_errors++; $display("FAIL single_link_active: got %b expected 1", link_active); end
        n_checks++; if (ovr_cnt - b_ovr + dse_cnt - b_dse + disc_cnt - b_disc !== 0) begin
            n_errors++; $display("FAIL single_pulses: got %0d expected 0", ovr_cnt - b_ovr + dse_cnt - b_dse + disc_cnt - b_disc);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] pat [6];
        pat = '{10'h0CC, 10'h3FF, 10'h000, 10'h3FF, 10'h000, 10'h3FF};
        baseline();
        for (int i = 0; i < 6; i++) send_char(pat[i], 4);
        tick(4);
        n_checks++; if (rxq.size() !== 6) begin n_errors++; $display("FAIL b2b_count: got %0d expected 6", rxq.size()); end
        for (int i = 0; i < 6 && i < rxq.size(); i++) begin
            n_checks++; if (rxq[i] !== pat[i]) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rxq[i], pat[i]); end
        end
        n_checks++; if (ovr_cnt - b_ovr !== 0) begin n_errors++; $display("FAIL b2b_overrun: got %0d expected 0", ovr_cnt - b_ovr); end
        n_checks++; if (disc_cnt - b_disc !== 0) begin n_errors++; $display("FAIL b2b_disconnect: got %0d expected 0", disc_cnt - b_disc); end
    endtask

    task automatic test_overrun();
        baseline();
        rx_if.rx_ready = 1'b0;
        send_char(10'h0CC, 4);
        send_char(10'h3FF, 4);
        tick(4);
        n_checks++; if (rx_if.rx_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_valid_held: got %b expected 1", rx_if.rx_valid); end
        n_checks++; if (rx_if.rx_data !== 10'h0CC) begin n_errors++; $display("FAIL ovr_data_held: got %h expected 0cc", rx_if.rx_data); end
        n_checks++; if (ovr_cnt - b_ovr !== 1) begin n_errors++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt - b_ovr); end
        rx_if.rx_ready = 1'b1;
        tick(3);
        n_checks++; if (rx_if.rx_valid !== 1'b0) begin n_errors++; $display("FAIL ovr_valid_fall: got %b expected 0", rx_if.rx_valid); end
        n_checks++; if (rxq.size() !== 1) begin n_errors++; $display("FAIL ovr_count: got %0d expected 1", rxq.size()); end
        if (rxq.size() > 0) begin
            n_checks++; if (rxq[0] !== 10'h0CC) begin n_errors++; $display("FAIL ovr_accepted: got %h expected 0cc", rxq[0]); end
        end
        n_checks++; if (rx_if.rx_data !== 10'h0CC) begin n_errors++; $display("FAIL ovr_dropped_char: got %h expected 0cc", rx_if.rx_data); end
    endtask

    task automatic test_disconnect();
        int delta;
        tick(100);
        baseline();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 4);
        delta = last_drive_cyc;
        tick(100);
        delta = disc_cyc - delta;
        n_checks++; if (disc_cnt - b_disc !== 1) begin n_errors++; $display("FAIL disc_pulses: got %0d expected 1", disc_cnt - b_disc); end
        // Last line change -> synchroniser (SYNC) -> event register (1) -> DISC silent clocks.
        n_checks++; if (delta !== SYNC + 1 + DISC) begin n_errors++; $display("FAIL disc_timing: got %0d expected %0d", delta, SYNC + 1 + DISC); end
        n_checks++; if (link_active !== 1'b0) begin n_errors++; $display("FAIL disc_link_active: got %b expected 0", link_active); end
        send_char(10'h2A5, 4);
        tick(4);
        n_checks++; if (rxq.size() !== 1) begin n_errors++; $display("FAIL disc_next_count: got %0d expected 1", rxq.size()); end
        if (rxq.size() > 0) begin
            n_checks++; if (rxq[0] !== 10'h2A5) begin n_errors++; $display("FAIL disc_next_data: got %h expected 2a5", rxq[0]); end
        end
        n_checks++; if (link_active !== 1'b1) begin n_errors++; $display("FAIL disc_relink: got %b expected 1", link_active); end
    endtask

    task automatic test_ds_error();
        tick(100);
        baseline();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 4);
        tx_d = ~tx_d;
        tx_s = ~tx_s;
        d_in = tx_d;
        s_in = tx_s;
        tick(4);
        send_char(10'h155, 4);
        tick(4);
        n_checks++; if (dse_cnt - b_dse !== 1) begin n_errors++; $display("FAIL dse_pulses: got %0d expected 1", dse_cnt - b_dse); end
        n_checks++; if (rxq.size() !== 1) begin n_errors++; $display("FAIL dse_count: got %0d expected 1", rxq.size()); end
        if (rxq.size() > 0) begin
            n_checks++; if (rxq[0] !== 10'h155) begin n_errors++; $display("FAIL dse_data: got %h expected 155", rxq[0]); end
        end
        n_checks++; if (ovr_cnt - b_ovr !== 0) begin n_errors++; $display("FAIL dse_overrun: got %0d expected 0", ovr_cnt - b_ovr); end
    endtask

    task automatic test_reset_mid_char();
        logic [N-1:0] c;
        c = 10'h3C3;
        tick(100);
        for (int k = 0; k < 6; k++) send_bit(c[k], 4);
        baseline();
        rst_n = 1'b0;
        d_in = 1'b0; s_in = 1'b0; tx_d = 1'b0; tx_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_checks++; if ({rx_if.rx_valid, rx_overrun, ds_error, disconnect, link_active} !== 5'b0) begin
                n_errors++; $display("FAIL rstmid_flags[%0d]: got %b expected 00000", i, {rx_if.rx_valid, rx_overrun, ds_error, disconnect, link_active});
            end
            n_checks++; if (rx_if.rx_data !== '0) begin n_errors++; $display("FAIL rstmid_data[%0d]: got %h expected 000", i, rx_if.rx_data); end
        end
        rst_n = 1'b1;
        tick(3);
        send_char(c, 4);
        tick(4);
        n_checks++; if (rxq.size() !== 1) begin n_errors++; $display("FAIL rstmid_count: got %0d expected 1", rxq.size()); end
        if (rxq.size() > 0) begin
            n_checks++; if (rxq[0] !== 10'h3C3) begin n_errors++; $display("FAIL rstmid_data: got %h expected 3c3", rxq[0]); end
        end
        n_checks++; if (ovr_cnt - b_ovr + dse_cnt - b_dse + disc_cnt - b_disc !== 0) begin
            n_errors++; $display("FAIL rstmid_pulses: got %0d expected 0", ovr_cnt - b_ovr + dse_cnt - b_dse + disc_cnt - b_disc);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_q[$];
        logic [N-1:0] c;
        tick(100);
        baseline();
        for (int i = 0; i < 12; i++) begin
            c = N'($urandom);
            exp_q.push_back(c);
            send_char(c, int'($urandom_range(3, 6)));
        end
        tick(6);
        n_checks++; if (rxq.size() !== exp_q.size()) begin n_errors++; $display("FAIL rand_count: got %0d expected %0d", rxq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rxq.size(); i++) begin
            n_checks++; if (rxq[i] !== exp_q[i]) begin n_errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, rxq[i], exp_q[i]); end
        end
        n_checks++; if (ovr_cnt - b_ovr + dse_cnt - b_dse + disc_cnt - b_disc !== 0) begin
            n_errors++; $display("FAIL rand_pulses: got %0d expected 0", ovr_cnt - b_ovr + dse_cnt - b_dse + disc_cnt - b_disc);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_disconnect();
        test_ds_error();
        test_reset_mid_char();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
